// File: rtl/pulse_compression_pkg.sv
// Shared definitions for the pulse-compression chain: default widths,
// detector state encoding and a counter-width helper.
package pulse_compression_pkg;

  // Upstream I/Q width; the magnitude stage widens this by one bit.
  localparam int DATA_WIDTH_DEFAULT = 18;
  localparam int MAG_WIDTH          = DATA_WIDTH_DEFAULT + 1;

  // Peak detector states; encodings are shared with the magnitude stage bench.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    HOLDOFF = 2'd2
  } pd_state_t;

  // Bits needed to hold values 0..max_value, never less than one bit.
  function automatic int count_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/sample_index_counter.sv
// Enable-gated wrapping counter. A clear together with an increment loads 1,
// which lets a run counter start at the first sample of a new region.
module sample_index_counter #(
  parameter int INDEX_WIDTH = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_clear,
  input  logic                   i_inc,
  output logic [INDEX_WIDTH-1:0] o_count
);

  logic [INDEX_WIDTH-1:0] r_count;

  // Count register: synchronous active-low reset, clear has priority, wraps silently.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= INDEX_WIDTH'(i_inc);
    end else if (i_inc) begin
      r_count <= r_count + INDEX_WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/magnitude_peak_detector.sv
// Threshold peak detector for the magnitude stream: tracks the maximum of
// each above-threshold region, reports it as a one-cycle event, then ignores
// a fixed number of samples before re-arming.
module magnitude_peak_detector
  import pulse_compression_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int INDEX_WIDTH = 16,
  parameter int HOLDOFF_LEN = 4,
  parameter int MAX_RUN     = 16
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   enable,
  input  logic [DATA_WIDTH:0]    dataIn,
  input  logic [DATA_WIDTH:0]    threshold,
  output logic                   peakValid,
  output logic [DATA_WIDTH:0]    peakValue,
  output logic [INDEX_WIDTH-1:0] peakIndex,
  output logic [7:0]             peakCount,
  output logic                   busy
);

  localparam int RUN_W  = count_width(MAX_RUN);
  localparam int HOLD_W = count_width(HOLDOFF_LEN);

  pd_state_t              r_state, w_state_next;
  logic [DATA_WIDTH:0]    r_max_val, w_max_val_next;
  logic [INDEX_WIDTH-1:0] r_max_idx, w_max_idx_next;
  logic                   r_peak_valid, w_peak_valid_next;
  logic [DATA_WIDTH:0]    r_peak_value, w_peak_value_next;
  logic [INDEX_WIDTH-1:0] r_peak_index, w_peak_index_next;
  logic [7:0]             r_peak_count, w_peak_count_next;
  logic                   r_busy, w_busy_next;

  logic                   w_above;
  logic                   w_report;
  logic                   w_run_clear, w_run_inc;
  logic                   w_hold_clear, w_hold_inc;
  logic [INDEX_WIDTH-1:0] w_sample_idx;
  logic [RUN_W-1:0]       w_run_count;
  logic [HOLD_W-1:0]      w_hold_count;

  assign w_above = (dataIn > threshold);

  // Free-running index of accepted samples, independent of detector state.
  sample_index_counter #(.INDEX_WIDTH(INDEX_WIDTH)) u_sample_index (
    .i_clock   (clock),
    .i_reset_n (resetN),
    .i_clear   (1'b0),
    .i_inc     (enable),
    .o_count   (w_sample_idx)
  );

  // Number of above-threshold samples held in the current region.
  sample_index_counter #(.INDEX_WIDTH(RUN_W)) u_run_count (
    .i_clock   (clock),
    .i_reset_n (resetN),
    .i_clear   (w_run_clear),
    .i_inc     (w_run_inc),
    .o_count   (w_run_count)
  );

  // Number of samples ignored since the last report.
  sample_index_counter #(.INDEX_WIDTH(HOLD_W)) u_hold_count (
    .i_clock   (clock),
    .i_reset_n (resetN),
    .i_clear   (w_hold_clear),
    .i_inc     (w_hold_inc),
    .o_count   (w_hold_count)
  );

  // State and output registers; reset discards any region and pending report.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state      <= IDLE;
      r_max_val    <= '0;
      r_max_idx    <= '0;
      r_peak_valid <= 1'b0;
      r_peak_value <= '0;
      r_peak_index <= '0;
      r_peak_count <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_max_val    <= w_max_val_next;
      r_max_idx    <= w_max_idx_next;
      r_peak_valid <= w_peak_valid_next;
      r_peak_value <= w_peak_value_next;
      r_peak_index <= w_peak_index_next;
      r_peak_count <= w_peak_count_next;
      r_busy       <= w_busy_next;
    end
  end

  // Next-state logic: region tracking, forced report on run overflow, holdoff.
  always_comb begin
    w_state_next      = r_state;
    w_max_val_next    = r_max_val;
    w_max_idx_next    = r_max_idx;
    w_peak_valid_next = 1'b0;
    w_peak_value_next = r_peak_value;
    w_peak_index_next = r_peak_index;
    w_peak_count_next = r_peak_count;
    w_report          = 1'b0;
    w_run_clear       = 1'b0;
    w_run_inc         = 1'b0;
    w_hold_clear      = 1'b0;
    w_hold_inc        = 1'b0;

    if (enable) begin
      case (r_state)
        IDLE: begin
          if (w_above) begin
            w_state_next   = SEARCH;
            w_max_val_next = dataIn;
            w_max_idx_next = w_sample_idx;
            w_run_clear    = 1'b1;
            w_run_inc      = 1'b1;
          end
        end
        SEARCH: begin
          // A full run forces a report; the overflowing sample is dropped.
          if (w_above && (int'(w_run_count) != MAX_RUN)) begin
            w_run_inc = 1'b1;
            if (dataIn > r_max_val) begin
              w_max_val_next = dataIn;
              w_max_idx_next = w_sample_idx;
            end
          end else begin
            w_report = 1'b1;
          end
        end
        HOLDOFF: begin
          w_hold_inc = 1'b1;
          if (int'(w_hold_count) + 1 >= HOLDOFF_LEN) begin
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase

      if (w_report) begin
        w_peak_valid_next = 1'b1;
        w_peak_value_next = r_max_val;
        w_peak_index_next = r_max_idx;
        if (r_peak_count != 8'hFF) begin
          w_peak_count_next = r_peak_count + 8'd1;
        end
        w_hold_clear = 1'b1;
        w_run_clear  = 1'b1;
        w_state_next = (HOLDOFF_LEN == 0) ? IDLE : HOLDOFF;
      end
    end

    w_busy_next = (w_state_next != IDLE);
  end

  assign peakValid = r_peak_valid;
  assign peakValue = r_peak_value;
  assign peakIndex = r_peak_index;
  assign peakCount = r_peak_count;
  assign busy      = r_busy;

endmodule

// File: tb/tb_magnitude_peak_detector.sv
// Bench for magnitude_peak_detector: a queue-based region model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_magnitude_peak_detector;

  localparam int DW   = 18;
  localparam int MW   = DW + 1;
  localparam int IW   = 16;
  localparam int HOLD = 4;
  localparam int RUN  = 16;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          enable = 1'b0;
  logic [MW-1:0] dataIn = '0;
  logic [MW-1:0] threshold = MW'(1000);
  logic          peakValid;
  logic [MW-1:0] peakValue;
  logic [IW-1:0] peakIndex;
  logic [7:0]    peakCount;
  logic          busy;

  always #5 clock = ~clock;

  magnitude_peak_detector #(
    .DATA_WIDTH  (DW),
    .INDEX_WIDTH (IW),
    .HOLDOFF_LEN (HOLD),
    .MAX_RUN     (RUN)
  ) dut (
    .clock     (clock),
    .resetN    (resetN),
    .enable    (enable),
    .dataIn    (dataIn),
    .threshold (threshold),
    .peakValid (peakValid),
    .peakValue (peakValue),
    .peakIndex (peakIndex),
    .peakCount (peakCount),
    .busy      (busy)
  );

  // Reference model: the open region is a list of (value, index) samples,
  // the holdoff is a number of samples still to be ignored.
  typedef struct {
    logic [MW-1:0] v;
    logic [IW-1:0] i;
  } samp_t;

  samp_t         region[$];
  int            ignore_left = 0;
  logic [IW-1:0] m_idx = '0;
  bit            model_on = 1'b0;
  logic          exp_valid = 1'b0;
  logic [MW-1:0] exp_value = '0;
  logic [IW-1:0] exp_index = '0;
  logic [7:0]    exp_count = '0;
  logic          exp_busy = 1'b0;

  int            n_vec = 0;
  int            n_err = 0;
  int            n_events = 0;
  logic [MW-1:0] ev_value = '0;
  logic [IW-1:0] ev_index = '0;
  logic [7:0]    ev_count = '0;

  // Model update on each rising edge from the inputs the DUT also samples.
  always @(posedge clock) begin : model
    samp_t best;
    samp_t s;
    if (!resetN) begin
      model_on = 1'b1;
      region.delete();
      ignore_left = 0;
      m_idx = '0;
      exp_valid = 1'b0;
      exp_value = '0;
      exp_index = '0;
      exp_count = '0;
    end else begin
      exp_valid = 1'b0;
      if (enable) begin
        s.v = dataIn;
        s.i = m_idx;
        if (ignore_left > 0) begin
          ignore_left--;
        end else if (region.size() == 0) begin
          if (dataIn > threshold) region.push_back(s);
        end else if ((dataIn > threshold) && (region.size() < RUN)) begin
          region.push_back(s);
        end else begin
          best = region[0];
          foreach (region[k]) if (region[k].v > best.v) best = region[k];
          exp_valid = 1'b1;
          exp_value = best.v;
          exp_index = best.i;
          if (exp_count != 8'd255) exp_count = exp_count + 8'd1;
          region.delete();
          ignore_left = HOLD;
        end
        m_idx = m_idx + IW'(1);
      end
    end
    exp_busy = (region.size() != 0) || (ignore_left != 0);
  end

  // Per-cycle comparison away from the active edge; also logs peak events.
  always @(negedge clock) begin
    if (model_on) begin
      n_vec++;
      if (peakValid !== exp_valid || peakValue !== exp_value || peakIndex !== exp_index ||
          peakCount !== exp_count || busy !== exp_busy) begin
        n_err++;
        $display("FAIL cycle t=%0t got v=%b val=%0d idx=%0d cnt=%0d busy=%b want v=%b val=%0d idx=%0d cnt=%0d busy=%b",
                 $time, peakValid, peakValue, peakIndex, peakCount, busy,
                 exp_valid, exp_value, exp_index, exp_count, exp_busy);
      end
      if (peakValid === 1'b1) begin
        n_events++;
        ev_value = peakValue;
        ev_index = peakIndex;
        ev_count = peakCount;
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  task automatic drive(input logic en, input int d);
    enable = en;
    dataIn = MW'(d);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    resetN = 1'b0;
    for (int k = 0; k < n; k++) begin
      enable = k[0];
      dataIn = MW'($urandom_range(0, 5000));
      @(posedge clock);
      #1;
    end
    resetN = 1'b1;
    enable = 1'b0;
  endtask

  int s2_data[7] = '{0, 500, 1200, 3000, 2500, 800, 0};
  int s3_data[5] = '{1000, 1500, 2000, 2000, 900};
  int s4_data[12] = '{0, 0, 1200, 1200, 1200, 0, 5000, 5000, 5000, 5000, 5000, 0};

  initial begin : stim
    int e0;
    bit hi;
    // 1. Reset with enable toggling.
    do_reset(10);
    drive(1'b0, 0);
    check_lit("reset_valid", 32'(peakValid), 0);
    check_lit("reset_value", 32'(peakValue), 0);
    check_lit("reset_index", 32'(peakIndex), 0);
    check_lit("reset_count", 32'(peakCount), 0);
    check_lit("reset_busy", 32'(busy), 0);

    // 2. Single peak.
    e0 = n_events;
    foreach (s2_data[k]) drive(1'b1, s2_data[k]);
    drive(1'b0, 0);
    check_lit("s2_events", 32'(n_events - e0), 1);
    check_lit("s2_value", 32'(ev_value), 3000);
    check_lit("s2_index", 32'(ev_index), 3);
    check_lit("s2_count", 32'(ev_count), 1);

    // 3. Equality does not start a region; ties keep the earlier index.
    do_reset(1);
    e0 = n_events;
    drive(1'b1, s3_data[0]);
    check_lit("s3_eq_busy", 32'(busy), 0);
    for (int k = 1; k < 5; k++) drive(1'b1, s3_data[k]);
    drive(1'b0, 0);
    check_lit("s3_events", 32'(n_events - e0), 1);
    check_lit("s3_value", 32'(ev_value), 2000);
    check_lit("s3_index", 32'(ev_index), 2);

    // 4. Holdoff ignores four samples, the fifth starts a new region.
    do_reset(1);
    e0 = n_events;
    foreach (s4_data[k]) drive(1'b1, s4_data[k]);
    drive(1'b0, 0);
    check_lit("s4_events", 32'(n_events - e0), 2);
    check_lit("s4_value", 32'(ev_value), 5000);
    check_lit("s4_index", 32'(ev_index), 10);
    check_lit("s4_count", 32'(ev_count), 2);

    // 5. Forced report after MAX_RUN samples.
    do_reset(1);
    e0 = n_events;
    for (int k = 0; k < 20; k++) drive(1'b1, 1500);
    check_lit("s5_events", 32'(n_events - e0), 1);
    check_lit("s5_value", 32'(ev_value), 1500);
    check_lit("s5_index", 32'(ev_index), 0);
    check_lit("s5_busy_hold", 32'(busy), 1);
    drive(1'b1, 0);
    check_lit("s5_busy_idle", 32'(busy), 0);

    // 6. Enable gaps, then reset in the middle of a region.
    do_reset(1);
    e0 = n_events;
    foreach (s2_data[k]) begin
      drive(1'b1, s2_data[k]);
      drive(1'b0, 7777);
    end
    check_lit("s6_events", 32'(n_events - e0), 1);
    check_lit("s6_value", 32'(ev_value), 3000);
    check_lit("s6_index", 32'(ev_index), 3);
    drive(1'b1, 0);
    drive(1'b1, 0);
    drive(1'b1, 1200);
    drive(1'b1, 3000);
    e0 = n_events;
    do_reset(1);
    drive(1'b0, 0);
    check_lit("s6_rst_events", 32'(n_events - e0), 0);
    check_lit("s6_rst_count", 32'(peakCount), 0);
    check_lit("s6_rst_busy", 32'(busy), 0);
    drive(1'b1, 1200);
    drive(1'b1, 0);
    drive(1'b0, 0);
    check_lit("s6_restart_index", 32'(ev_index), 0);
    check_lit("s6_restart_count", 32'(ev_count), 1);

    // Random traffic: bursty data on a 100 grid so ties and equality occur.
    hi = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 40 == 0) hi = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) == 0) threshold = MW'($urandom_range(5, 20) * 100);
      resetN = ($urandom_range(0, 499) != 0);
      enable = ($urandom_range(0, 3) != 0);
      if (hi && $urandom_range(0, 29) != 0)
        dataIn = threshold + MW'($urandom_range(0, 30) * 100);
      else
        dataIn = MW'($urandom_range(0, 30) * 100);
      @(posedge clock);
      #1;
    end
    resetN = 1'b1;
    drive(1'b0, 0);
    drive(1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
